imm_gen_pipe: RTL

//  Parametrised, pipelined successor to the combinational immediate generator.

---
 rtl/imm_gen_pipe_if.sv | 29 ++
 rtl/imm_gen_pipe.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module : imm_gen_pipe_if
//  Brief  : Instruction-in / immediate-out handshake bundle for imm_gen_pipe.
//  Rev    : 1.0  initial release
// ============================================================================
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr_in;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm_out;
    logic [2:0]      imm_type;
    logic            illegal;

    modport slave (
        input  in_valid, instr_in, out_ready,
        output in_ready, out_valid, imm_out, imm_type, illegal
    );

    modport master (
        output in_valid, instr_in, out_ready,
        input  in_ready, out_valid, imm_out, imm_type, illegal
    );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module : imm_gen_pipe
//  Brief  : Registered RV32I/RV64I immediate decoder behind a 2-entry skid FIFO,
//           with a saturating illegal-opcode counter.
//  Rev    : 1.0  initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             flush,
    imm_gen_pipe_if.slave         bus,
    output logic [CNT_W-1:0]      illegal_count
);
    localparam logic [2:0] c_TYPE_R   = 3'd0;
    localparam logic [2:0] c_TYPE_I   = 3'd1;
    localparam logic [2:0] c_TYPE_S   = 3'd2;
    localparam logic [2:0] c_TYPE_B   = 3'd3;
    localparam logic [2:0] c_TYPE_U   = 3'd4;
    localparam logic [2:0] c_TYPE_J   = 3'd5;
    localparam logic [2:0] c_TYPE_ILL = 3'd7;
    localparam logic [5:0] c_SHAMT_MASK = (XLEN == 64) ? 6'h3F : 6'h1F;

    logic [31:0]     w_instr;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_type;
    logic            w_ill;
    logic            w_push;
    logic            w_pop;
    logic [1:0]      w_count_nxt;

    logic [XLEN-1:0]  r_imm  [2];
    logic [2:0]       r_type [2];
    logic             r_ill  [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_ill_cnt;

    assign w_instr = bus.instr_in;

    // Every format is first built as a 32-bit signed value; widening to XLEN is
    // then a plain sign extension (shamt has its top bit clear, so it stays zext).
    always_comb begin
        w_imm32 = 32'd0;
        w_type  = c_TYPE_ILL;
        w_ill   = 1'b1;
        case (w_instr[6:0])
            7'd3, 7'd103: begin
                w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
                w_type  = c_TYPE_I;
                w_ill   = 1'b0;
            end
            7'd19: begin
                if (w_instr[14:12] == 3'b001 || w_instr[14:12] == 3'b101)
                    w_imm32 = {26'd0, w_instr[25:20] & c_SHAMT_MASK};
                else
                    w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
                w_type = c_TYPE_I;
                w_ill  = 1'b0;
            end
            7'd35: begin
                w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
                w_type  = c_TYPE_S;
                w_ill   = 1'b0;
            end
            7'd99: begin
                w_imm32 = {{20{w_instr[31]}}, w_instr[7], w_instr[30:25],
                           w_instr[11:8], 1'b0};
                w_type  = c_TYPE_B;
                w_ill   = 1'b0;
            end
            7'd23, 7'd55: begin
                w_imm32 = {w_instr[31:12], 12'd0};
                w_type  = c_TYPE_U;
                w_ill   = 1'b0;
            end
            7'd111: begin
                w_imm32 = {{12{w_instr[31]}}, w_instr[19:12], w_instr[20],
                           w_instr[30:21], 1'b0};
                w_type  = c_TYPE_J;
                w_ill   = 1'b0;
            end
            7'd51: begin
                w_type = c_TYPE_R;
                w_ill  = 1'b0;
            end
            default: begin
                w_imm32 = 32'd0;
                w_type  = c_TYPE_ILL;
                w_ill   = 1'b1;
            end
        endcase
    end

    generate
        if (XLEN == 64) begin : g_xlen64
            assign w_imm = {{32{w_imm32[31]}}, w_imm32};
        end else begin : g_xlen32
            assign w_imm = w_imm32;
        end
    endgenerate

    // in_ready is the registered view of count<2, so a pop at count==2 cannot admit a push.
    assign w_push = bus.in_valid && r_in_ready;
    assign w_pop  = (r_count != 2'd0) && bus.out_ready;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + 2'd1;
        else if (!w_push && w_pop)
            w_count_nxt = r_count - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                r_imm[k]  <= '0;
                r_type[k] <= 3'd0;
                r_ill[k]  <= 1'b0;
            end
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
            r_ill_cnt  <= '0;
        end else if (flush) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_imm[r_wr_ptr]  <= w_imm;
                r_type[r_wr_ptr] <= w_type;
                r_ill[r_wr_ptr]  <= w_ill;
                r_wr_ptr         <= ~r_wr_ptr;
                if (w_ill && (r_ill_cnt != {CNT_W{1'b1}}))
                    r_ill_cnt <= r_ill_cnt + CNT_W'(1);
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != 2'd2);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = (r_count != 2'd0);
    assign bus.imm_out   = r_imm[r_rd_ptr];
    assign bus.imm_type  = r_type[r_rd_ptr];
    assign bus.illegal   = r_ill[r_rd_ptr];
    assign illegal_count = r_ill_cnt;

endmodule
`default_nettype wire
